ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Boot-time loader sitting directly upstream of the 16-bit data/instruction RAM.
- Consumes a byte stream from the UART receiver, assembles big-endian 16-bit words and drives the RAM write port (address, in, load) sequentially from START_ADDR.
- Releases the RAM port and signals done when the image is complete, so the CPU can come out of reset.

Parameters:
- START_ADDR, 0, first RAM word address written.
- DEPTH, 2048, number of writable RAM words; words beyond this are discarded.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored while busy.
- rx_valid  input  1  UART byte available.
- rx_data  input  8  UART byte.
- rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
- address  output  16  RAM word address.
- wr_data  output  16  RAM write data; connects to RAM in.
- load  output  1  RAM write enable; one-cycle pulse per word.
- busy  output  1  load in progress; the RAM port is owned by the loader.
- done  output  1  level; set on completion, cleared by start or reset.
- overflow  output  1  image length exceeded DEPTH; sticky until start or reset.
- word_count  output  16  words accepted so far in the current load.

Behaviour:
- Reset values:
  - address = START_ADDR.
  - wr_data, word_count, length register = 0.
  - load, rx_ready, busy, done, overflow = 0.
  - State = IDLE.
- Reset mid-load abandons the transfer: load deasserts the same edge and no partial word is written.
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent as high byte then low byte.
- States:
  - IDLE: rx_ready=0. On start → LEN_HI; busy=1, done=0, overflow=0, word_count=0, address=START_ADDR.
  - LEN_HI: rx_ready=1. Accepted byte → len[15:8]; → LEN_LO.
  - LEN_LO: rx_ready=1. Accepted byte → len[7:0]. If {len_hi, byte}==0 → FIN; else → DATA_HI.
  - DATA_HI: rx_ready=1. Byte → wr_data[15:8]; → DATA_LO.
  - DATA_LO: rx_ready=1. Byte → wr_data[7:0]; → WRITE.
  - WRITE: rx_ready=0.
    - load=1 for exactly this one cycle, with address and wr_data stable across the whole cycle. The RAM samples on negedge inside this cycle.
    - On exit: word_count+1 and address+1.
    - If word_count+1 == len → FIN, else → DATA_HI.
  - FIN: busy=0, done=1 → IDLE.
- Latency: load asserts in the cycle after the low byte is accepted. Minimum word period is 3 cycles.
- Overflow:
  - Applies when (address − START_ADDR) ≥ DEPTH in WRITE.
  - load stays 0 (word discarded) and overflow=1.
  - Counting continues, so the stream is still fully consumed.
  - address does not increment past the last valid address.
- address arithmetic is 16-bit modulo. A len of 0xFFFF with START_ADDR=0 still terminates via the word_count compare.
- A start arriving in any state other than IDLE is ignored.
- rx_valid while rx_ready=0: the byte is not consumed; the UART holds it.
- Outputs are registered. load, address and wr_data change only on posedge.

Optional Feature:
- RAM_LOADER_CHECKSUM_EN
  - Defined:
    - After the last data byte, the FSM enters CHK (rx_ready=1), expecting one byte equal to the 8-bit modulo sum of all LEN and data bytes.
    - Adds output chk_err (1 bit, reset 0, cleared on start), set in FIN on mismatch.
    - With N=0 the checksum byte still follows LEN_LO.
  - Undefined: no CHK state, no trailing byte, chk_err port absent.

Decomposition:
- Shared package ram_loader_pkg:
  - State enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, FIN).
  - Constants WORD_W=16, BYTE_W=8.
  - Default START_ADDR/DEPTH.
- Natural sub-module: byte_pair_assembler, which holds the high byte, merges the low byte and flags word-ready.
- FSM, counters and overflow logic stay in the top.

Test Plan:
- Stream 00 02 12 34 AB CD after start → writes 0x1234@0 and 0xABCD@1; each load is 1 cycle; done=1; word_count=2; RAM readback matches.
- Stream 00 00 → no load pulse; done=1 two cycles after LEN_LO is accepted; busy returns to 0.
- DEPTH=4, len=6 → 4 writes at 0..3; the remaining 2 words are consumed with load=0; overflow=1; done=1; word_count=6.
- Reset asserted between DATA_HI and DATA_LO of word 1 → next edge: load=0, busy=0, state IDLE; RAM word 1 unchanged; a fresh start loads correctly.
- rx_valid held with gaps and a start pulse mid-load → no byte lost or duplicated; start is ignored; address sequence is contiguous.
- With RAM_LOADER_CHECKSUM_EN: 00 01 12 34 + 0x47 → chk_err=0; sending 0x48 instead → chk_err=1, and the RAM word is still written.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the boot-time RAM loader.
// The optional trailing checksum byte is enabled by RAM_LOADER_CHECKSUM_EN.
package ram_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] DEF_START_ADDR = 16'h0000;
  localparam int unsigned       DEF_DEPTH      = 2048;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    CHK     = 3'd6,
    FIN     = 3'd7
  } state_t;

  // States in which the loader consumes a UART byte.
  function automatic logic takes_byte(input state_t st);
    case (st)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK: takes_byte = 1'b1;
      default:                               takes_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_loader_byte_pair_assembler.sv
// Builds a big-endian 16-bit word from two accepted bytes (high byte first)
// and flags the cycle in which the low byte completes the word.
module ram_loader_byte_pair_assembler
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic              take_hi,
  input  logic              take_lo,
  input  logic [BYTE_W-1:0] data_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] word_r;

  assign word_ready = byte_valid && take_lo;
  assign word       = word_r;

  // Word register: high byte lands first, low byte completes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r <= 16'h0000;
    end else if (byte_valid && take_hi) begin
      word_r[15:8] <= data_byte;
    end else if (word_ready) begin
      word_r[7:0] <= data_byte;
    end else begin
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> sequential RAM word writes.
// Define RAM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte and expose chk_err.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [15:0] START_ADDR = DEF_START_ADDR,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic [WORD_W-1:0] address,
  output logic [WORD_W-1:0] wr_data,
  output logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [WORD_W-1:0] word_count
`ifdef RAM_LOADER_CHECKSUM_EN
  ,
  output logic              chk_err
`endif
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = FIN;
`endif

  state_t            state_r, state_s;
  logic              rx_ready_r, load_r, busy_r, done_r, overflow_r;
  logic [WORD_W-1:0] address_r, word_count_r, len_r;
  logic [WORD_W-1:0] offset_s, cnt_inc_s;
  logic              accept_s, in_range_s, take_hi_s, take_lo_s, word_ready_s;

  assign accept_s   = rx_valid && rx_ready_r;
  assign take_hi_s  = (state_r == DATA_HI);
  assign take_lo_s  = (state_r == DATA_LO);
  assign offset_s   = address_r - START_ADDR;
  // Window test is done in 17 bits so DEPTH up to 65536 still works.
  assign in_range_s = ({1'b0, offset_s} < DEPTH_L);
  assign cnt_inc_s  = word_count_r + 16'd1;

  ram_loader_byte_pair_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept_s),
    .take_hi    (take_hi_s),
    .take_lo    (take_lo_s),
    .data_byte  (rx_data),
    .word       (wr_data),
    .word_ready (word_ready_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LEN_HI; else state_s = IDLE;
      LEN_HI:  if (accept_s) state_s = LEN_LO; else state_s = LEN_HI;
      LEN_LO: begin
        if (accept_s) begin
          if ({len_r[15:8], rx_data} == 16'h0000) state_s = END_ST;
          else                                    state_s = DATA_HI;
        end else begin
          state_s = LEN_LO;
        end
      end
      DATA_HI: if (accept_s) state_s = DATA_LO; else state_s = DATA_HI;
      DATA_LO: if (word_ready_s) state_s = WRITE; else state_s = DATA_LO;
      WRITE:   if (cnt_inc_s == len_r) state_s = END_ST; else state_s = DATA_HI;
`ifdef RAM_LOADER_CHECKSUM_EN
      CHK:     if (accept_s) state_s = FIN; else state_s = CHK;
`else
      CHK:     state_s = IDLE;
`endif
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; address saturates once the window is full.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready_r   <= 1'b0;
      load_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      address_r    <= START_ADDR;
      word_count_r <= 16'h0000;
      len_r        <= 16'h0000;
    end else begin
      rx_ready_r <= takes_byte(state_s);
      load_r     <= (state_s == WRITE) && in_range_s;
      if (state_r == IDLE && start) begin
        busy_r       <= 1'b1;
        done_r       <= 1'b0;
        overflow_r   <= 1'b0;
        address_r    <= START_ADDR;
        word_count_r <= 16'h0000;
        len_r        <= 16'h0000;
      end else begin
        if (accept_s && state_r == LEN_HI) len_r[15:8] <= rx_data;
        if (accept_s && state_r == LEN_LO) len_r[7:0]  <= rx_data;
        if (state_s == WRITE && !in_range_s) overflow_r <= 1'b1;
        if (state_r == WRITE) begin
          word_count_r <= cnt_inc_s;
          if (in_range_s) address_r <= address_r + 16'd1;
        end
        if (state_r == FIN) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_r;
  logic              chk_ok_r, chk_err_r;

  // Running byte sum over LEN and data bytes, verdict latched in FIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r     <= 8'h00;
      chk_ok_r  <= 1'b0;
      chk_err_r <= 1'b0;
    end else if (state_r == IDLE && start) begin
      sum_r     <= 8'h00;
      chk_ok_r  <= 1'b0;
      chk_err_r <= 1'b0;
    end else begin
      if (accept_s && state_r != CHK) sum_r <= sum_r + rx_data;
      if (accept_s && state_r == CHK) chk_ok_r <= (rx_data == sum_r);
      if (state_r == FIN) chk_err_r <= !chk_ok_r;
    end
  end

  assign chk_err = chk_err_r;
`endif

  assign rx_ready   = rx_ready_r;
  assign address    = address_r;
  assign load       = load_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign overflow   = overflow_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench: two loaders share one byte stream; A uses defaults,
// B starts at 16'hFFFE with DEPTH=4 (address wrap and overflow).
module tb_ram_loader;

  localparam logic [15:0] SA_A    = 16'h0000;
  localparam logic [15:0] SA_B    = 16'hFFFE;
  localparam int          DEPTH_B = 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready_a, load_a, busy_a, done_a, overflow_a;
  logic        rx_ready_b, load_b, busy_b, done_b, overflow_b;
  logic [15:0] address_a, wr_data_a, word_count_a;
  logic [15:0] address_b, wr_data_b, word_count_b;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic        chk_err_a, chk_err_b;
`endif

  int n_asserts = 0, n_fail = 0;
  int nload_a = 0, nload_b = 0, dbl_a = 0, dbl_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [15:0] ram_a [65536];
  logic [15:0] ram_b [65536];
  logic [15:0] exp_a [65536];
  logic [15:0] exp_b [65536];
  logic [15:0] wq[$];

  ram_loader dut_a (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready_a), .address(address_a), .wr_data(wr_data_a), .load(load_a),
    .busy(busy_a), .done(done_a), .overflow(overflow_a), .word_count(word_count_a)
`ifdef RAM_LOADER_CHECKSUM_EN
    , .chk_err(chk_err_a)
`endif
  );

  ram_loader #(.START_ADDR(SA_B), .DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready_b), .address(address_b), .wr_data(wr_data_b), .load(load_b),
    .busy(busy_b), .done(done_b), .overflow(overflow_b), .word_count(word_count_b)
`ifdef RAM_LOADER_CHECKSUM_EN
    , .chk_err(chk_err_b)
`endif
  );

  initial forever #5 clk = ~clk;

  // RAM models sample on negedge, as the real RAM does.
  always @(negedge clk) begin
    prev_a <= load_a;
    prev_b <= load_b;
    if (load_a) begin ram_a[address_a] <= wr_data_a; nload_a <= nload_a + 1; end
    if (load_b) begin ram_b[address_b] <= wr_data_b; nload_b <= nload_b + 1; end
    if (load_a && prev_a) dbl_a <= dbl_a + 1;
    if (load_b && prev_b) dbl_b <= dbl_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap = $urandom_range(0, 2);
    int tmo = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    while (!rx_ready_a && tmo < 50) begin @(negedge clk); tmo++; end
    check("rx_ready_timeout", (tmo < 50), 1'b1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends the image in wq; a start pulse is injected before word start_at.
  task automatic run_load(input int start_at, input bit bad_chk);
    int          n = wq.size();
    logic [15:0] n16 = 16'(n);
    logic [7:0]  sum;
    logic [15:0] w;
    int          la0 = nload_a, lb0 = nload_b, cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    sum = n16[15:8] + n16[7:0];
    send_byte(n16[15:8]);
    check("busy_a_in_load", busy_a, 1'b1);
    check("ovf_b_cleared", overflow_b, 1'b0);
    check("done_a_cleared", done_a, 1'b0);
    send_byte(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      if (i == start_at) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
      check("load_a_latency", load_a, 1'b1);
      check("addr_a", address_a, 16'(SA_A + 16'(i)));
      check("wdata_a", wr_data_a, w);
      check("load_b_window", load_b, (i < DEPTH_B));
      if (i < DEPTH_B) check("addr_b", address_b, 16'(SA_B + 16'(i)));
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? 8'(sum + 8'd1) : sum);
`endif
    while (!done_a && cyc < 10) begin @(posedge clk); #1; cyc++; end
`ifndef RAM_LOADER_CHECKSUM_EN
    if (n == 0) check("done_latency_n0", cyc, 1);
`endif
    check("done_a", done_a, 1'b1);
    check("done_b", done_b, 1'b1);
    check("busy_a_end", busy_a, 1'b0);
    check("busy_b_end", busy_b, 1'b0);
    check("rx_ready_b_end", rx_ready_b, 1'b0);
    check("wcount_a", word_count_a, n16);
    check("wcount_b", word_count_b, n16);
    check("ovf_a", overflow_a, 1'b0);
    check("ovf_b", overflow_b, (n > DEPTH_B));
`ifdef RAM_LOADER_CHECKSUM_EN
    check("chk_err_a", chk_err_a, bad_chk);
    check("chk_err_b", chk_err_b, bad_chk);
`endif
    @(negedge clk); @(negedge clk);
    check("nloads_a", nload_a - la0, n);
    check("nloads_b", nload_b - lb0, (n < DEPTH_B) ? n : DEPTH_B);
    check("load_single_a", dbl_a, 0);
    check("load_single_b", dbl_b, 0);
    for (int i = 0; i < n; i++) begin
      exp_a[16'(SA_A + 16'(i))] = wq[i];
      if (i < DEPTH_B) exp_b[16'(SA_B + 16'(i))] = wq[i];
    end
    for (int i = 0; i < n; i++) begin
      check("ram_a", ram_a[16'(SA_A + 16'(i))], exp_a[16'(SA_A + 16'(i))]);
      check("ram_b", ram_b[16'(SA_B + 16'(i))], exp_b[16'(SA_B + 16'(i))]);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_a", address_a, SA_A);
    check("rst_addr_b", address_b, SA_B);
    check("rst_wdata", wr_data_a, 16'h0000);
    check("rst_load", load_a, 1'b0);
    check("rst_ready", rx_ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_ovf", overflow_a, 1'b0);
    check("rst_wcount", word_count_a, 16'h0000);
    @(negedge clk); reset = 1'b0;

    wq = '{16'h1234, 16'hABCD};
    run_load(-1, 1'b0);

    wq = {};
    run_load(-1, 1'b0);

    wq = {};
    for (int i = 0; i < 6; i++) wq.push_back(16'($urandom));
    run_load(-1, 1'b0);

    // Reset between the two bytes of word 1.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h5A); send_byte(8'hC3);
    send_byte(8'h77);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_load", load_a, 1'b0);
    check("rst_mid_busy", busy_a, 1'b0);
    check("rst_mid_ready", rx_ready_a, 1'b0);
    check("rst_mid_wcount", word_count_a, 16'h0000);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    exp_a[SA_A] = 16'h5AC3;
    exp_b[SA_B] = 16'h5AC3;
    check("rst_mid_w0_a", ram_a[SA_A], exp_a[SA_A]);
    check("rst_mid_w1_a", ram_a[16'(SA_A + 16'd1)], exp_a[16'(SA_A + 16'd1)]);
    check("rst_mid_w1_b", ram_b[16'(SA_B + 16'd1)], exp_b[16'(SA_B + 16'd1)]);

    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 8);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      run_load((t == 0) ? -1 : $urandom_range(0, n - 1), 1'b0);
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    wq = '{16'h1234};
    run_load(-1, 1'b0);
    run_load(-1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
